ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

PS/2 device-to-host receiver that sits directly upstream of the peripherals subsystem on the `ps2_clk`/`ps2_data` pad pair. It synchronises and de-glitches the pad signals and deserialises 11-bit PS/2 frames. Parity and framing are checked, and good scan codes are buffered in a small FIFO. The downstream register/interrupt logic drains the FIFO through a valid/ready port.

## Interface
- `FIFO_DEPTH`, 8: scan-code FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 8: cycles a synchronised `ps2_clk` level must hold before the filtered clock follows it; ≥1.
- `TIMEOUT_CYCLES`, 50000: idle cycles allowed between bits inside a frame (2 ms at 25 MHz).
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: raw pad clock, asynchronous.
- `ps2_data` in 1: raw pad data, asynchronous.
- `rx_data_o` out 8: FIFO head scan code.
- `rx_valid_o` out 1: FIFO non-empty.
- `rx_ready_i` in 1: consumer pop; a pop happens when `rx_valid_o && rx_ready_i`.
- `fifo_count_o` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `parity_err_o` out 1: sticky; a frame was dropped on parity.
- `frame_err_o` out 1: sticky; bad start bit, bad stop bit, or timeout.
- `overflow_o` out 1: sticky; a good byte was dropped because the FIFO was full.
- `err_clr_i` in 1: pulse; clears all three sticky flags.
- `irq_o` out 1: level interrupt, equal to `rx_valid_o | parity_err_o | frame_err_o | overflow_o`.

## Operation
- **Input synchronisation:** `ps2_clk` and `ps2_data` each pass through 2-flop synchronisers. Both synchroniser outputs reset to 1.
- **Glitch filter:** the filtered clock `fclk` (reset 1) takes the synchronised clock value once that value has differed from `fclk` for `FILTER_LEN` consecutive cycles. Any shorter excursion restarts the count.
- **Bit strobe:** a one-cycle `fall` strobe fires when `fclk` goes 1→0. Synchronised data is sampled in the `fall` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, sampled 0 moves to DATA with bit index 0. Sampled 1 sets `frame_err_o` and the FSM stays in IDLE.
  - DATA: on each `fall`, shift the bit in LSB first. After bit 7 move to PARITY.
  - PARITY: on `fall`, latch the parity bit and move to STOP.
  - STOP: on `fall`, return to IDLE, then classify the frame:
    - stop bit 0: set `frame_err_o`, no push.
    - stop bit 1 but `^{data,parity}` ≠ 1 (odd parity): set `parity_err_o`, no push.
    - otherwise push the byte.
- **Timeout:** in DATA/PARITY/STOP, the timer counts cycles since the last `fall`. Reaching `TIMEOUT_CYCLES` sets `frame_err_o` and forces IDLE; the partial byte is discarded.
- **FIFO:** a push while full is dropped and sets `overflow_o`. If push and pop occur in the same cycle while full, the push is accepted and the count is unchanged. Simultaneous push and pop at any level also leaves the count unchanged.
- **Flag priority:** if a flag set and `err_clr_i` occur in the same cycle, set wins.
- **Reset values:** all outputs 0, FIFO empty, FSM IDLE, timer 0, `fclk` 1. Reset mid-frame discards the partial frame.

## Timing
- Pad edge to `fall`: 2 synchroniser cycles + `FILTER_LEN` cycles + 1 register cycle.
- Push latency: the byte is written in the cycle after the stop-bit `fall`. `rx_valid_o` and `fifo_count_o` update one cycle later. With defaults, the stop-bit pad edge reaches `rx_valid_o` in 13 cycles.
- FIFO output: `rx_data_o` is registered FIFO head data and is valid whenever `rx_valid_o`=1. A pop takes effect in the same cycle, and the next entry appears the following cycle.
- Throughput: one byte per PS/2 frame (~1 ms). The FIFO never back-pressures the line; excess bytes are dropped.

## Structure
- Package `ps2_pkg` holds:
  - `ps2_state_e` enum (IDLE, DATA, PARITY, STOP);
  - frame constants `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11;
  - error-flag bit indices.
- One sub-module, `ps2_sync_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count ports.
- The synchronisers, glitch filter, FSM, timer and flags live in the top module.

## Test plan
- **Good frame:** send 0x1C with parity 0 and stop 1, 60 µs bit period. Expect `rx_data_o`=0x1C, `rx_valid_o`=1, `fifo_count_o`=1, `irq_o`=1, and no flags. Pulse `rx_ready_i` → count returns to 0.
- **Parity error:** send 0x1C with parity 1. Expect no push, `parity_err_o`=1 and `irq_o`=1. After `err_clr_i`, all flags read 0.
- **Timeout and recovery:** stop clocking after 5 data bits and wait `TIMEOUT_CYCLES`. Expect `frame_err_o`=1 and FSM back in IDLE. A following 0xF0 frame is received intact.
- **Overflow:** send 9 good frames 0x01..0x09 without pops. Expect count 8 and `overflow_o`=1. Draining returns 0x01..0x08 in order.
- **Glitch rejection:** drive a `FILTER_LEN`-1 cycle low pulse on `ps2_clk` while in IDLE. Expect no state change and no flags.
- **Reset mid-frame:** assert `rst_n`=0 for one cycle after 4 data bits. Expect all outputs 0. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame FSM state enum, frame sizes and sticky error-flag bit indices.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  localparam int ERR_PARITY = 0;
  localparam int ERR_FRAME  = 1;
  localparam int ERR_OVF    = 2;
  localparam int ERR_W      = 3;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO for received scan codes; head entry shown on data_o.
// Ports: push_i/data_i write, pop_i read, full_o/empty_o/count_o status.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot, so a push while full is accepted alongside it.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM, scan-code FIFO.
// Ports: ps2_clk/ps2_data pads in; rx_* valid/ready out; sticky errors, irq_o.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          err_clr_i,
  output logic                          irq_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_s1_q, clk_s2_q;
  logic             dat_s1_q, dat_s2_q;
  logic             fclk_q, fclk_d;
  logic             fclk_dly_q;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             fall_q, fall_d;
  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             push_q, push_d;
  logic [ERR_W-1:0] err_q, err_d, err_set;
  logic             fifo_full, fifo_empty, pop;

  // Filtered clock follows only after FILTER_LEN stable differing cycles.
  always_comb begin
    fclk_d = fclk_q;
    fcnt_d = '0;
    if (clk_s2_q != fclk_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        fclk_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = fclk_dly_q & ~fclk_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_d    = 1'b0;
    err_set   = '0;
    timer_d   = (state_q == IDLE) ? '0 : timer_q + 1'b1;
    if (fall_q) begin
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            err_set[ERR_FRAME] = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s2_q)                   err_set[ERR_FRAME]  = 1'b1;
          else if (!(^{shift_q, par_q}))   err_set[ERR_PARITY] = 1'b1;
          else                             push_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d            = IDLE;
      timer_d            = '0;
      err_set[ERR_FRAME] = 1'b1;
    end
    if (push_q && fifo_full && !pop) err_set[ERR_OVF] = 1'b1;
    err_d = err_set | (err_q & ~{ERR_W{err_clr_i}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fclk_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      timer_q    <= '0;
      push_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      fclk_q     <= fclk_d;
      fclk_dly_q <= fclk_q;
      fcnt_q     <= fcnt_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      timer_q    <= timer_d;
      push_q     <= push_d;
      err_q      <= err_d;
    end
  end

  assign pop = rx_valid_o && rx_ready_i;

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign rx_valid_o   = !fifo_empty;
  assign parity_err_o = err_q[ERR_PARITY];
  assign frame_err_o  = err_q[ERR_FRAME];
  assign overflow_o   = err_q[ERR_OVF];
  assign irq_o        = rx_valid_o | (|err_q);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames, errors, overflow, glitch, reset.
// Short bit period and timeout keep the run small.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int FLEN  = 8;
  localparam int TOUT  = 400;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       parity_err, frame_err, overflow;
  logic       err_clr = 1'b0;
  logic       irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .fifo_count_o (fifo_count),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .overflow_o   (overflow),
    .err_clr_i    (err_clr),
    .irq_o        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic send(input logic [7:0] d, input logic p,
                      input logic s, input int nbits);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) bit_out(f[i]);
    ps2_data = 1'b1;
    cyc(60);
  endtask

  task automatic pop1;
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic clr;
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, {overflow, frame_err, parity_err}, exp);
  endtask

  initial begin
    logic [7:0] b;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_irq", irq, 0);
    chk_flags("rst_flags", 3'b000);

    send(8'h1C, 1'b0, 1'b1, 11);
    chk("good_data", rx_data, 8'h1C);
    chk("good_valid", rx_valid, 1);
    chk("good_count", fifo_count, 1);
    chk("good_irq", irq, 1);
    chk_flags("good_flags", 3'b000);
    pop1();
    chk("good_popcnt", fifo_count, 0);
    chk("good_popirq", irq, 0);

    send(8'h1C, 1'b1, 1'b1, 11);
    chk("par_valid", rx_valid, 0);
    chk_flags("par_flags", 3'b001);
    chk("par_irq", irq, 1);
    clr();
    chk_flags("par_clr", 3'b000);
    chk("par_clrirq", irq, 0);

    send(8'hA5, 1'b0, 1'b1, 6);
    chk("to_early", frame_err, 0);
    cyc(TOUT + 50);
    chk_flags("to_flags", 3'b010);
    chk("to_state", dut.state_q, IDLE);
    chk("to_valid", rx_valid, 0);
    clr();
    send(8'hF0, 1'b1, 1'b1, 11);
    chk("to_data", rx_data, 8'hF0);
    chk("to_count", fifo_count, 1);
    chk_flags("to_rcv_flags", 3'b000);
    pop1();

    bit_out(1'b1);
    cyc(30);
    chk_flags("start1_flags", 3'b010);
    chk("start1_state", dut.state_q, IDLE);
    clr();

    ps2_clk = 1'b0;
    cyc(FLEN - 1);
    ps2_clk = 1'b1;
    cyc(40);
    chk("gl_state", dut.state_q, IDLE);
    chk_flags("gl_flags", 3'b000);
    chk("gl_count", fifo_count, 0);

    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send(b, ~^b, 1'b1, 11);
    end
    chk("ovf_count", fifo_count, 8);
    chk_flags("ovf_flags", 3'b100);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d", i), rx_data, i);
      pop1();
    end
    chk("drain_count", fifo_count, 0);
    chk("drain_valid", rx_valid, 0);
    clr();

    send(8'h1C, 1'b0, 1'b1, 11);
    send(8'h33, 1'b0, 1'b1, 5);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mr_valid", rx_valid, 0);
    chk("mr_count", fifo_count, 0);
    chk("mr_data", rx_data, 0);
    chk("mr_irq", irq, 0);
    chk("mr_state", dut.state_q, IDLE);
    send(8'h5A, 1'b1, 1'b1, 11);
    chk("mr_rdata", rx_data, 8'h5A);
    chk("mr_rcount", fifo_count, 1);
    chk_flags("mr_flags", 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
